lfsr_seq_ctrl: RTL and testbench
================================

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 SHALL have parameter CYC_W, default 8: width of num_cycles and cycle_cnt.
REQ-002 SHALL have parameter SET_W, default 8: width of settle_len.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  in  1: asynchronous, active-low (0 = in reset); the block has one clock, and reset is asynchronous and active-low.
REQ-005 SHALL have port sym_en  in  1: symbol-rate strobe, one clk wide.
REQ-006 SHALL have port start  in  1: level; sampled only in IDLE.
REQ-007 SHALL have port stop  in  1: level; aborts any active window.
REQ-008 SHALL have port cont  in  1: 1 = restart a new window automatically after DONE.
REQ-009 SHALL have port num_cycles  in  CYC_W: full LFSR periods per window; 0 is treated as 1.
REQ-010 SHALL have port settle_len  in  SET_W: sym_en strobes of pipeline fill before accumulation.
REQ-011 SHALL have port lfsr_cycle_done  in  1: period-complete pulse from the LFSR (periodic output).
REQ-012 SHALL have port lfsr_clk_en  out  1: clock enable to the LFSR.
REQ-013 SHALL have port lfsr_rst  out  1: active-high synchronous-style reset pulse to the LFSR.
REQ-014 SHALL have port acc_clear  out  1: one-clk clear to the downstream accumulators.
REQ-015 SHALL have port acc_en  out  1: accumulate strobe.
REQ-016 SHALL have port window_done  out  1: one-clk pulse when a window completes.
REQ-017 SHALL have port abort  out  1: one-clk pulse when stop ends a window.
REQ-018 SHALL have port busy  out  1: high in every state except IDLE.
REQ-019 SHALL have port cycle_cnt  out  CYC_W: periods completed in the current window.
REQ-020 SHALL have port state  out  3: encoding IDLE=0, RST=1, SETTLE=2, RUN=3, DONE=4.

Function
REQ-021 SHALL implement the FSM IDLE, RST, SETTLE, RUN, DONE with a registered state.
REQ-022 IDLE: when start=1 and stop=0, SHALL go to RST next clk.
REQ-023 RST: SHALL last exactly one clk, with lfsr_rst=1 and acc_clear=1 registered and coincident with state RST; cycle_cnt and the settle counter SHALL clear to 0; next state is SETTLE, or RUN if settle_len=0.
REQ-024 SETTLE: the settle counter SHALL increment on each sym_en; on the sym_en that makes the count equal settle_len, the FSM SHALL go to RUN next clk.
REQ-025 RUN: cycle_cnt SHALL increment on each lfsr_cycle_done=1; when the incremented value equals max(num_cycles,1), the FSM SHALL go to DONE next clk.
REQ-026 DONE: SHALL last one clk with window_done=1 and cycle_cnt held; next state is RST if cont=1, else IDLE.
REQ-027 lfsr_clk_en SHALL be combinational sym_en AND (state is SETTLE or RUN), giving zero latency; it SHALL be 0 in IDLE, RST and DONE.
REQ-028 acc_en SHALL be combinational sym_en AND (state is RUN).
REQ-029 num_cycles and settle_len SHALL be captured into internal registers in RST; changes mid-window SHALL have no effect.
REQ-030 stop=1 in RST, SETTLE, RUN or DONE SHALL force IDLE next clk with abort=1 for one clk.
REQ-031 stop SHALL take priority over lfsr_cycle_done, window_done and cont in the same clk; no window_done pulse occurs on abort.
REQ-032 start asserted while busy=1 SHALL be ignored; start held high in IDLE after a completion SHALL launch a new window.
REQ-033 cycle_cnt SHALL retain its last value in IDLE until the next RST.
REQ-034 lfsr_cycle_done outside RUN SHALL be ignored.
REQ-035 Any unused state encoding SHALL return to IDLE next clk.

Reset
REQ-036 reset=0 SHALL asynchronously force state=IDLE and all registered outputs to 0: lfsr_rst, acc_clear, window_done, abort and cycle_cnt.
REQ-037 With reset=0, busy, lfsr_clk_en and acc_en SHALL be 0.
REQ-038 Deassertion of reset mid-window SHALL resume in IDLE; no pulse outputs SHALL fire on the first clk after release.

Verification
REQ-039 Single window: num_cycles=2, settle_len=3, sym_en every 4 clks, start pulse, lfsr_cycle_done pulsed twice in RUN -> one lfsr_rst/acc_clear clk, exactly 3 SETTLE strobes with acc_en=0, window_done one clk after the 2nd pulse, cycle_cnt=2, return to IDLE.
REQ-040 Zero configs: num_cycles=0, settle_len=0 -> RST goes directly to RUN; window_done follows the first lfsr_cycle_done.
REQ-041 Abort: stop asserted in the same clk as the final lfsr_cycle_done in RUN -> abort=1, window_done=0, IDLE next clk, cycle_cnt not incremented.
REQ-042 Continuous: cont=1, num_cycles=1 -> the sequence DONE, RST, SETTLE repeats with lfsr_rst pulsing once per window; start toggles while busy have no effect.
REQ-043 Async reset: reset=0 asserted mid-RUN, between clk edges -> outputs 0 immediately; after release, IDLE and no pulse on the first clk.
REQ-044 Config stability: num_cycles changed from 3 to 1 during RUN -> the window still completes after 3 lfsr_cycle_done pulses.

Source files
------------

// File: rtl/lfsr_seq_ctrl_if.sv
// Control/status bundle between the LFSR window sequencer and its environment
// (host controls, LFSR handshake, accumulator strobes).
interface lfsr_seq_ctrl_if #(
  parameter int CYC_W = 8,
  parameter int SET_W = 8
);
  logic             sym_en;
  logic             start;
  logic             stop;
  logic             cont;
  logic [CYC_W-1:0] num_cycles;
  logic [SET_W-1:0] settle_len;
  logic             lfsr_cycle_done;

  logic             lfsr_clk_en;
  logic             lfsr_rst;
  logic             acc_clear;
  logic             acc_en;
  logic             window_done;
  logic             abort;
  logic             busy;
  logic [CYC_W-1:0] cycle_cnt;
  logic [2:0]       state;

  modport master (
    output sym_en, start, stop, cont, num_cycles, settle_len, lfsr_cycle_done,
    input  lfsr_clk_en, lfsr_rst, acc_clear, acc_en, window_done, abort, busy,
           cycle_cnt, state
  );

  modport slave (
    input  sym_en, start, stop, cont, num_cycles, settle_len, lfsr_cycle_done,
    output lfsr_clk_en, lfsr_rst, acc_clear, acc_en, window_done, abort, busy,
           cycle_cnt, state
  );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// Measurement-window sequencer: resets the LFSR, waits out pipeline fill, then
// accumulates over a configured number of full LFSR periods.
module lfsr_seq_ctrl #(
  parameter int CYC_W = 8,
  parameter int SET_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  lfsr_seq_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_q;
  logic [CYC_W-1:0] cycle_cnt_q;
  logic [CYC_W-1:0] num_cycles_q;
  logic [SET_W-1:0] settle_cnt_q;
  logic [SET_W-1:0] settle_len_q;
  logic             lfsr_rst_q;
  logic             acc_clear_q;
  logic             window_done_q;
  logic             abort_q;

  logic [CYC_W-1:0] cycle_cnt_inc;
  logic [SET_W-1:0] settle_cnt_inc;

  assign cycle_cnt_inc  = cycle_cnt_q + CYC_W'(1);
  assign settle_cnt_inc = settle_cnt_q + SET_W'(1);

  // Counters clear on entry to RST so the RST cycle already shows cycle_cnt=0,
  // while the configuration is latched on the way out of RST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cycle_cnt_q   <= '0;
      num_cycles_q  <= '0;
      settle_cnt_q  <= '0;
      settle_len_q  <= '0;
      lfsr_rst_q    <= 1'b0;
      acc_clear_q   <= 1'b0;
      window_done_q <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      lfsr_rst_q    <= 1'b0;
      acc_clear_q   <= 1'b0;
      window_done_q <= 1'b0;
      abort_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state_q      <= RST;
            lfsr_rst_q   <= 1'b1;
            acc_clear_q  <= 1'b1;
            cycle_cnt_q  <= '0;
            settle_cnt_q <= '0;
          end
        end
        RST: begin
          if (bus.stop) begin
            state_q <= IDLE;
            abort_q <= 1'b1;
          end else begin
            num_cycles_q <= (bus.num_cycles == '0) ? CYC_W'(1) : bus.num_cycles;
            settle_len_q <= bus.settle_len;
            state_q      <= (bus.settle_len == '0) ? RUN : SETTLE;
          end
        end
        SETTLE: begin
          if (bus.stop) begin
            state_q <= IDLE;
            abort_q <= 1'b1;
          end else if (bus.sym_en) begin
            settle_cnt_q <= settle_cnt_inc;
            if (settle_cnt_inc == settle_len_q) begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_q <= IDLE;
            abort_q <= 1'b1;
          end else if (bus.lfsr_cycle_done) begin
            cycle_cnt_q <= cycle_cnt_inc;
            if (cycle_cnt_inc == num_cycles_q) begin
              state_q       <= DONE;
              window_done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.stop) begin
            state_q <= IDLE;
            abort_q <= 1'b1;
          end else if (bus.cont) begin
            state_q      <= RST;
            lfsr_rst_q   <= 1'b1;
            acc_clear_q  <= 1'b1;
            cycle_cnt_q  <= '0;
            settle_cnt_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Enables are combinational so the LFSR advances on the same strobe it sees.
  assign bus.lfsr_clk_en = bus.sym_en && ((state_q == SETTLE) || (state_q == RUN));
  assign bus.acc_en      = bus.sym_en && (state_q == RUN);
  assign bus.busy        = (state_q != IDLE);
  assign bus.lfsr_rst    = lfsr_rst_q;
  assign bus.acc_clear   = acc_clear_q;
  assign bus.window_done = window_done_q;
  assign bus.abort       = abort_q;
  assign bus.cycle_cnt   = cycle_cnt_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl: windows are predicted from per-clock
// sym_en / lfsr_cycle_done event lists by counting events, plus directed corner cases.
module tb_lfsr_seq_ctrl;
  localparam int CYC_W = 8;
  localparam int SET_W = 8;
  localparam int LEN   = 64;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  bit   sym_a [LEN];
  bit   cd_a  [LEN];

  lfsr_seq_ctrl_if #(.CYC_W(CYC_W), .SET_W(SET_W)) bus ();

  lfsr_seq_ctrl #(.CYC_W(CYC_W), .SET_W(SET_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input bit st, input bit sp, input bit ct,
                                input bit se, input bit cd);
    bus.start           = st;
    bus.stop            = sp;
    bus.cont            = ct;
    bus.sym_en          = se;
    bus.lfsr_cycle_done = cd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_random();
    for (int j = 0; j < LEN; j++) begin
      sym_a[j] = ($urandom_range(1, 0) == 1) || (j % 4 == 0);
      cd_a[j]  = ($urandom_range(2, 0) == 0) || (j % 8 == 0);
    end
  endtask

  // Edge 0 samples start; RUN begins after the s-th strobe seen in SETTLE
  // (edges >= 2), DONE after the max(n,1)-th cycle_done seen in RUN.
  task automatic run_window(input string name, input int s, input int n, input bit scramble);
    int eff_n;
    int e_s;
    int e_d;
    int hits;
    int cnt;
    int exp_st;
    bit go;
    eff_n = (n == 0) ? 1 : n;
    e_s   = (s == 0) ? 1 : -1;
    hits  = 0;
    for (int j = 2; j < LEN; j++) begin
      if (s != 0 && e_s < 0 && sym_a[j]) begin
        hits++;
        if (hits == s) e_s = j;
      end
    end
    e_d  = -1;
    hits = 0;
    if (e_s >= 0) begin
      for (int j = e_s + 1; j < LEN; j++) begin
        if (e_d < 0 && cd_a[j]) begin
          hits++;
          if (hits == eff_n) e_d = j;
        end
      end
    end
    go = (e_d >= 0) && (e_d + 2 < LEN);
    check_output({name, " fits"}, 32'(go), 32'd1);
    if (go) begin
      bus.num_cycles = CYC_W'(n);
      bus.settle_len = SET_W'(s);
      apply_stimulus(1'b1, 1'b0, 1'b0, sym_a[0], cd_a[0]);
      cnt = 0;
      for (int t = 0; t <= e_d + 1; t++) begin
        tick();
        if (t == 0)        exp_st = 1;
        else if (t < e_s)  exp_st = 2;
        else if (t < e_d)  exp_st = 3;
        else if (t == e_d) exp_st = 4;
        else               exp_st = 0;
        if (t > e_s && t <= e_d && cd_a[t]) cnt++;
        check_output({name, " state"}, 32'(bus.state), exp_st);
        check_output({name, " cycle_cnt"}, 32'(bus.cycle_cnt), cnt);
        check_output({name, " busy"}, 32'(bus.busy), 32'(exp_st != 0));
        check_output({name, " lfsr_rst"}, 32'(bus.lfsr_rst), 32'(t == 0));
        check_output({name, " acc_clear"}, 32'(bus.acc_clear), 32'(t == 0));
        check_output({name, " window_done"}, 32'(bus.window_done), 32'(t == e_d));
        check_output({name, " abort"}, 32'(bus.abort), 32'd0);
        if (scramble && t >= 1) begin
          bus.num_cycles = CYC_W'($urandom);
          bus.settle_len = SET_W'($urandom);
        end
        apply_stimulus((t <= e_d) ? 1'($urandom_range(1, 0)) : 1'b0, 1'b0, 1'b0,
                       sym_a[t+1], cd_a[t+1]);
        #1;
        check_output({name, " lfsr_clk_en"}, 32'(bus.lfsr_clk_en),
                     32'(sym_a[t+1] && (exp_st == 2 || exp_st == 3)));
        check_output({name, " acc_en"}, 32'(bus.acc_en), 32'(sym_a[t+1] && exp_st == 3));
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.num_cycles = '0;
    bus.settle_len = '0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    #3;
    check_output("rst state", 32'(bus.state), 32'd0);
    check_output("rst busy", 32'(bus.busy), 32'd0);
    check_output("rst lfsr_clk_en", 32'(bus.lfsr_clk_en), 32'd0);
    check_output("rst acc_en", 32'(bus.acc_en), 32'd0);
    check_output("rst lfsr_rst", 32'(bus.lfsr_rst), 32'd0);
    check_output("rst acc_clear", 32'(bus.acc_clear), 32'd0);
    check_output("rst window_done", 32'(bus.window_done), 32'd0);
    check_output("rst abort", 32'(bus.abort), 32'd0);
    check_output("rst cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #3 reset = 1'b1;
    tick();
    check_output("release state", 32'(bus.state), 32'd0);
    check_output("release lfsr_rst", 32'(bus.lfsr_rst), 32'd0);
    check_output("release abort", 32'(bus.abort), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int j = 0; j < LEN; j++) begin
      sym_a[j] = (j % 4 == 0);
      cd_a[j]  = (j == 5 || j == 20 || j == 27);
    end
    run_window("single", 3, 2, 1'b0);

    for (int j = 0; j < LEN; j++) begin
      sym_a[j] = 1'b1;
      cd_a[j]  = (j == 1 || j == 3 || j == 6);
    end
    run_window("zero_cfg", 0, 0, 1'b0);

    for (int j = 0; j < LEN; j++) begin
      sym_a[j] = (j % 2 == 0);
      cd_a[j]  = (j % 5 == 0);
    end
    run_window("cfg_hold", 1, 3, 1'b1);

    for (int w = 0; w < 6; w++) begin
      gen_random();
      run_window("rand", int'($urandom_range(4, 0)), int'($urandom_range(3, 0)), 1'b1);
    end

    // Stop coincident with the final period pulse wins over completion.
    bus.num_cycles = CYC_W'(1);
    bus.settle_len = '0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_output("abort rst", 32'(bus.state), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_output("abort run", 32'(bus.state), 32'd3);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("abort state", 32'(bus.state), 32'd0);
    check_output("abort pulse", 32'(bus.abort), 32'd1);
    check_output("abort window_done", 32'(bus.window_done), 32'd0);
    check_output("abort cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_output("abort clears", 32'(bus.abort), 32'd0);
    check_output("abort idle", 32'(bus.state), 32'd0);

    // Continuous mode: RST, SETTLE, RUN, DONE repeating every 4 clks.
    bus.num_cycles = CYC_W'(1);
    bus.settle_len = SET_W'(1);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int t = 0; t < 12; t++) begin
      tick();
      check_output("cont state", 32'(bus.state), 32'((t % 4) + 1));
      check_output("cont lfsr_rst", 32'(bus.lfsr_rst), 32'(t % 4 == 0));
      check_output("cont window_done", 32'(bus.window_done), 32'(t % 4 == 3));
      check_output("cont cycle_cnt", 32'(bus.cycle_cnt), 32'(t % 4 == 3));
      apply_stimulus(1'($urandom_range(1, 0)), 1'b0, 1'b1, 1'b1, 1'b1);
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check_output("cont stop state", 32'(bus.state), 32'd0);
    check_output("cont stop abort", 32'(bus.abort), 32'd1);
    check_output("cont stop lfsr_rst", 32'(bus.lfsr_rst), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_output("cont idle abort", 32'(bus.abort), 32'd0);

    // Asynchronous reset in the middle of RUN, between clock edges.
    bus.num_cycles = CYC_W'(3);
    bus.settle_len = '0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check_output("areset run", 32'(bus.state), 32'd3);
    check_output("areset cnt0", 32'(bus.cycle_cnt), 32'd0);
    tick();
    check_output("areset cnt1", 32'(bus.cycle_cnt), 32'd1);
    check_output("areset acc_en", 32'(bus.acc_en), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_output("areset state", 32'(bus.state), 32'd0);
    check_output("areset busy", 32'(bus.busy), 32'd0);
    check_output("areset cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
    check_output("areset lfsr_clk_en", 32'(bus.lfsr_clk_en), 32'd0);
    check_output("areset acc_en off", 32'(bus.acc_en), 32'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    tick();
    check_output("post state", 32'(bus.state), 32'd0);
    check_output("post lfsr_rst", 32'(bus.lfsr_rst), 32'd0);
    check_output("post acc_clear", 32'(bus.acc_clear), 32'd0);
    check_output("post abort", 32'(bus.abort), 32'd0);
    check_output("post window_done", 32'(bus.window_done), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
